// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for a word-indexed, registered-read data memory.
// Sub-word stores are read-modify-write; one request in flight.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned, illegal-size and out-of-range requests
// with resp_err and no memory access. Undefined: low address bits ignored, size 11 acts as word.
module load_store_unit #(
  parameter int unsigned MEM_WORDS     = 1024,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_data_in
);

  localparam int unsigned DW  = 32;
  localparam int unsigned SHW = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // One-hot so every strobe is a plain register bit.
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    RD   = 5'b00010,
    CAP  = 5'b00100,
    WR   = 5'b01000,
    RESP = 5'b10000
  } state_e;

  state_e state_q, state_d;

  logic           write_q, write_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [1:0]     lane_q, lane_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           accept;
  logic           req_err;
  logic [1:0]     size_eff;
  logic [DW-1:0]  req_idx;
  logic           idx_oob;
  logic [SHW-1:0] lane_sh;
  logic [DW-1:0]  lane_mask;
  logic [DW-1:0]  rd_shifted;
  logic [DW-1:0]  load_ext;
  logic [DW-1:0]  merged;

  assign accept   = req_valid & (state_q == IDLE);
  assign size_eff = (req_size == SZ_ILL) ? SZ_WORD : req_size;
  assign req_idx  = {2'b00, req_addr[DW-1:2]};
  assign idx_oob  = (req_idx >= DW'(MEM_WORDS));

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_err = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                 | idx_oob;
`else
  logic unused_idx_oob;
  assign unused_idx_oob = idx_oob;
  assign req_err        = 1'b0;
`endif

  // Bit offset and mask of the addressed lane within the memory word.
  always_comb begin
    lane_sh   = '0;
    lane_mask = '1;
    case (size_q)
      SZ_BYTE: begin
        lane_sh   = LITTLE_ENDIAN ? {lane_q, 3'b000} : {~lane_q, 3'b000};
        lane_mask = DW'(32'h0000_00FF) << lane_sh;
      end
      SZ_HALF: begin
        lane_sh   = LITTLE_ENDIAN ? {lane_q[1], 4'b0000} : {~lane_q[1], 4'b0000};
        lane_mask = DW'(32'h0000_FFFF) << lane_sh;
      end
      default: begin
        lane_sh   = '0;
        lane_mask = '1;
      end
    endcase
  end

  assign rd_shifted = mem_data_in >> lane_sh;
  assign merged     = (mem_data_in & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  // Lane select plus zero/sign extension of the captured read word.
  always_comb begin
    load_ext = rd_shifted;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h00_0000, rd_shifted[7:0]}
                                : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'h0000, rd_shifted[15:0]}
                                : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // State register; reset drops every strobe at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                               state_d = RESP;
          else if (req_write && size_eff == SZ_WORD) state_d = WR;
          else                                       state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the state register.
  always_comb begin
    req_ready  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready  = 1'b1;
      RD:      MemRead    = 1'b1;
      WR:      MemWrite   = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request latch, RMW merge and response capture.
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = size_eff;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          addr_d  = req_idx;
          if (req_write) wdata_d = req_wdata;
          if (req_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      CAP: begin
        if (write_q) begin
          wdata_d = merged;
        end else begin
          rdata_d = load_ext;
          err_d   = 1'b0;
        end
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of directed requests against a registered-read memory,
// plus hand-written reset-abort and back-to-back sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_data_in;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .MemWrite(MemWrite), .MemRead(MemRead), .mem_data_in(mem_data_in)
  );

  // Data memory: registered read, write on MemWrite, bench-side clear port.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rdata;
  logic        tb_we = 1'b0;
  logic [9:0]  tb_idx = '0;
  assign mem_data_in = mem_rdata;

  always @(posedge clk) begin
    if (tb_we)         mem[tb_idx] <= '0;
    else if (MemWrite) mem[mem_address[9:0]] <= mem_write_data;
    if (MemRead)       mem_rdata <= mem[mem_address[9:0]];
  end

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always @(negedge clk) if (MemRead && MemWrite) overlap++;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_word;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [31:0] exp_word, input int lat, input int nrd,
                              input int nwr);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_word = exp_word;
    v.exp_lat = lat; v.exp_rd = nrd; v.exp_wr = nwr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one request from an IDLE cycle, scramble req_* after accept, check the response.
  task automatic run_vec(input vec_t v, input string nm);
    int          lat, nrd, nwr;
    logic        done;
    logic [31:0] seen_addr;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    lat = 0; nrd = 0; nwr = 0; done = 1'b0; seen_addr = '0;
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_write = ~v.wr; req_size = 2'b00; req_unsigned = ~v.uns;
        req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
      end
      if (MemRead)  begin nrd++; seen_addr = mem_address; end
      if (MemWrite) begin nwr++; seen_addr = mem_address; end
      if (resp_valid) begin done = 1'b1; lat = k; end
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_nrd"}, 32'(nrd), 32'(v.exp_rd));
    chk({nm, "_nwr"}, 32'(nwr), 32'(v.exp_wr));
    chk({nm, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({nm, "_err"}, 32'(resp_err), 32'(v.exp_err));
    chk({nm, "_word"}, mem[v.addr[11:2]], v.exp_word);
    if (nrd + nwr > 0) chk({nm, "_idx"}, seen_addr, {2'b00, v.addr[31:2]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=%0d required=%0d", 0, 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr_r, nresp_r, acc, npulse;
    int p0, p1;

    // Clear memory while held in reset.
    tb_we = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      tb_idx = 10'(i);
      @(negedge clk);
    end
    tb_we = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b1;

    //              wr    sz     un    addr          wdata          rdata          er    word          lat rd wr
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 2, 0, 1));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 1, 0));
    vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_56AA, 32'h0000_0000, 1'b0, 32'hDEAD_AAEF, 4, 1, 1));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'hFFFF_FFAA, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_00AA, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 32'h1122_3344, 2, 0, 1));
    vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hABCD_8001, 32'h0000_0000, 1'b0, 32'h8001_3344, 4, 1, 1));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_3344, 1'b0, 32'h8001_3344, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'h0,         32'hFFFF_FF80, 1'b0, 32'h8001_3344, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0044, 1'b0, 32'h8001_3344, 3, 1, 0));
    vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'h0000_017F, 32'h0000_0000, 1'b0, 32'h8001_337F, 4, 1, 1));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h8001_337F, 1'b0, 32'h8001_337F, 3, 1, 0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 2, 0, 1));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0FFE, 32'h0,         32'hFFFF_FFFE, 1'b0, 32'hCAFE_F00D, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0FFC, 32'h0,         32'h0000_F00D, 1'b0, 32'hCAFE_F00D, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0FFE, 32'h0,         32'hFFFF_CAFE, 1'b0, 32'hCAFE_F00D, 3, 1, 0));
`ifdef LSU_MISALIGN_CHECK_EN
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 32'hDEAD_AAEF, 1, 0, 0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h0BAD_F00D, 32'h0000_0000, 1'b1, 32'hDEAD_AAEF, 1, 0, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0,         32'h0000_0000, 1'b1, 32'h8001_337F, 1, 0, 0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 32'hDEAD_AAEF, 1, 0, 0));
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0, 0));
`else
    vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_AAEF, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0, 32'hDEAD_AAEF, 3, 1, 0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0023, 32'h0,         32'hFFFF_8001, 1'b0, 32'h8001_337F, 3, 1, 0));
    vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 32'h0BAD_F00D, 2, 0, 1));
`endif

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], $sformatf("v%0d", i));

    // Reset during CAP of a byte store: no write, memory unchanged, idle after release.
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0012; req_wdata = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd", 32'(MemRead), 32'd1);
    @(negedge clk);
    chk("abort_cap_nowr", 32'(MemWrite), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_rst_rd", 32'(MemRead), 32'd0);
    chk("abort_rst_wr", 32'(MemWrite), 32'd0);
    chk("abort_rst_resp", 32'(resp_valid), 32'd0);
    nwr_r = 0; nresp_r = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      if (MemWrite)   nwr_r++;
      if (resp_valid) nresp_r++;
    end
    chk("abort_nwr", 32'(nwr_r), 32'd0);
    chk("abort_nresp", 32'(nresp_r), 32'd0);
    chk("abort_word", mem[4], 32'hDEAD_AAEF);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, 32'hDEAD_AAEF, 3, 1, 0), "abort_reload");

    // req_valid held across two loads: second accepted in the IDLE after RESP.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b01; req_unsigned = 1'b1;
    req_addr = 32'h0000_0012; req_wdata = '0;
    acc = req_ready ? 1 : 0;
    npulse = 0; p0 = -1; p1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (acc >= 2) req_valid = 1'b0;
      if (resp_valid) begin
        npulse++;
        if (npulse == 1) p0 = k; else p1 = k;
        chk($sformatf("b2b_rdata%0d", npulse), resp_rdata, 32'h0000_DEAD);
      end
      if (req_valid && req_ready) acc++;
    end
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_pulses", 32'(npulse), 32'd2);
    chk("b2b_first", 32'(p0), 32'd3);
    chk("b2b_gap", 32'(p1 - p0), 32'd4);

    chk("strobe_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
